// File: rtl/xdma_pkg.sv
// rtl/xdma_pkg.sv - shared widths and beat record for the XDMA C2H stream packer
//
// Purpose: common localparams and the FIFO entry type used by the packer and
//          its beat FIFO.
// Contents:
//   XDMA_IN_WIDTH    narrow input word width
//   XDMA_BEAT_WIDTH  AXI-stream beat width
//   XDMA_WORDS       input words per beat
//   xdma_beat_t      {last, data} entry stored in the beat FIFO
package xdma_pkg;

  localparam int XDMA_IN_WIDTH   = 64;
  localparam int XDMA_BEAT_WIDTH = 512;
  localparam int XDMA_WORDS      = XDMA_BEAT_WIDTH / XDMA_IN_WIDTH;

  typedef struct packed {
    logic                       last;
    logic [XDMA_BEAT_WIDTH-1:0] data;
  } xdma_beat_t;

endpackage

// File: rtl/xdma_beat_fifo.sv
// rtl/xdma_beat_fifo.sv - synchronous FIFO of packed output beats
//
// Purpose: small circular buffer between the word accumulator and the sink.
// Ports:
//   clock      in   single clock, posedge
//   reset      in   synchronous active-low reset, empties the FIFO
//   push       in   write push_data (ignored when full)
//   push_data  in   beat to store
//   pop        in   drop the head entry (ignored when empty)
//   head       out  oldest entry
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   count      out  number of entries stored
module xdma_beat_fifo
  import xdma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  xdma_beat_t               push_data,
  input  logic                     pop,
  output xdma_beat_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  xdma_beat_t       r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head      = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xdma_axis_packer.sv
// rtl/xdma_axis_packer.sv - packs narrow words into 512-bit AXI-stream beats
//
// Purpose: accumulates IN_WIDTH words (word 0 in the low bits) into beats,
//          closes a beat when full or on in_last, queues beats in a FIFO and
//          presents the head to the XDMA C2H sink.
// Ports:
//   clock       in   single clock, posedge
//   reset       in   synchronous active-low reset
//   in_valid    in   input word valid
//   in_ready    out  input word accepted when in_valid & in_ready
//   in_data     in   input word
//   in_last     in   word ends its packet
//   axi_tdata   out  beat data
//   axi_tlast   out  beat ends a packet
//   axi_tvalid  out  beat valid
//   axi_tready  in   sink ready
//   pkt_count   out  tlast handshakes, wrapping
//   beat_count  out  all handshakes, wrapping
module xdma_axis_packer
  import xdma_pkg::*;
#(
  parameter int IN_WIDTH   = XDMA_IN_WIDTH,
  parameter int OUT_WIDTH  = XDMA_BEAT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic [OUT_WIDTH-1:0] axi_tdata,
  output logic                 axi_tlast,
  output logic                 axi_tvalid,
  input  logic                 axi_tready,
  output logic [31:0]          pkt_count,
  output logic [31:0]          beat_count
);

  localparam int WORDS = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [OUT_WIDTH-1:0] r_acc;
  logic [IDX_W-1:0]     r_widx;
  logic [31:0]          r_pkt_count;
  logic [31:0]          r_beat_count;

  logic [OUT_WIDTH-1:0] w_beat;
  logic                 w_accept;
  logic                 w_complete;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  xdma_beat_t           w_push_beat;
  xdma_beat_t           w_head;

  // in_ready looks only at the registered occupancy, so a pop while full
  // frees the slot for the following cycle, never combinationally.
  assign in_ready   = reset & (w_count < CW'(FIFO_DEPTH));
  assign w_accept   = in_valid & in_ready;
  assign w_complete = w_accept & (in_last | (r_widx == IDX_W'(WORDS - 1)));
  assign w_push     = w_complete & ~w_full;

  // Current accumulator with the incoming word merged in; slots above the
  // write index are forced to zero so a short final beat carries no stale data.
  always_comb begin
    w_beat = r_acc;
    for (int i = 0; i < WORDS; i++) begin
      if (IDX_W'(i) == r_widx) begin
        w_beat[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end else if (IDX_W'(i) > r_widx) begin
        w_beat[i*IN_WIDTH +: IN_WIDTH] = '0;
      end
    end
  end

  assign w_push_beat = '{last: in_last, data: w_beat};

  xdma_beat_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_beat),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign axi_tvalid = reset & ~w_empty;
  assign axi_tdata  = w_head.data;
  assign axi_tlast  = w_head.last;
  assign w_pop      = axi_tvalid & axi_tready;
  assign pkt_count  = r_pkt_count;
  assign beat_count = r_beat_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc        <= '0;
      r_widx       <= '0;
      r_pkt_count  <= '0;
      r_beat_count <= '0;
    end else begin
      if (w_complete) begin
        r_acc  <= '0;
        r_widx <= '0;
      end else if (w_accept) begin
        r_acc  <= w_beat;
        r_widx <= r_widx + 1'b1;
      end
      if (w_pop) begin
        r_beat_count <= r_beat_count + 32'd1;
        if (axi_tlast) begin
          r_pkt_count <= r_pkt_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xdma_axis_packer.sv
// tb/tb_xdma_axis_packer.sv - self-checking bench for xdma_axis_packer
module tb_xdma_axis_packer;
  import xdma_pkg::*;

  localparam int W     = XDMA_IN_WIDTH;
  localparam int BW    = XDMA_BEAT_WIDTH;
  localparam int WORDS = XDMA_WORDS;

  typedef logic [BW:0] beat_t;

  typedef struct {
    int           nwords;
    logic [W-1:0] base;
    int           exp_beats;
    int           tail;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [BW-1:0] axi_tdata;
  logic          axi_tlast;
  logic          axi_tvalid;
  logic          axi_tready;
  logic [31:0]   pkt_count;
  logic [31:0]   beat_count;

  logic man_ready = 1'b1;
  logic rnd_ready = 1'b1;
  logic rand_mode = 1'b0;

  int    checks = 0;
  int    failures = 0;
  int    m_beats = 0;
  int    m_pkts = 0;
  int    rx_beats = 0;
  beat_t exp_q[$];

  assign axi_tready = rand_mode ? rnd_ready : man_ready;

  always #5 clock = ~clock;

  xdma_axis_packer #(
    .IN_WIDTH   (W),
    .OUT_WIDTH  (BW),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .axi_tdata  (axi_tdata),
    .axi_tlast  (axi_tlast),
    .axi_tvalid (axi_tvalid),
    .axi_tready (axi_tready),
    .pkt_count  (pkt_count),
    .beat_count (beat_count)
  );

  task automatic chk(input string nm, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: a packet's words split into WORDS-sized chunks, zero padded,
  // tlast only on the final chunk of a terminated packet.
  task automatic add_expected(input logic [W-1:0] wds[$], input logic last);
    int    n;
    int    nb;
    beat_t b;
    n  = wds.size();
    nb = (n + WORDS - 1) / WORDS;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int j = 0; j < WORDS; j++) begin
        if (k * WORDS + j < n) b[j*W +: W] = wds[k*WORDS + j];
      end
      b[BW] = last && (k == nb - 1);
      exp_q.push_back(b);
      m_beats++;
      if (b[BW]) m_pkts++;
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_packet(input logic [W-1:0] wds[$]);
    add_expected(wds, 1'b1);
    for (int i = 0; i < wds.size(); i++) send_word(wds[i], i == wds.size() - 1);
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clock);
      t++;
    end
    chk(nm, beat_t'(exp_q.size()), beat_t'(0));
    @(posedge clock);
    #1;
  endtask

  // Output monitor: scoreboard compare on every handshake plus AXI hold rule.
  initial begin : monitor
    logic  pv;
    logic  pr;
    beat_t pb;
    pv = 1'b0;
    pr = 1'b0;
    pb = '0;
    forever begin
      @(negedge clock);
      if (reset && pv && !pr) begin
        chk("hold_valid", beat_t'(axi_tvalid), beat_t'(1));
        chk("hold_data", {axi_tlast, axi_tdata}, pb);
      end
      if (reset && axi_tvalid && axi_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", {axi_tlast, axi_tdata});
        end else begin
          chk("beat", {axi_tlast, axi_tdata}, exp_q.pop_front());
        end
        rx_beats++;
      end
      pv = reset & axi_tvalid;
      pr = axi_tready;
      pb = {axi_tlast, axi_tdata};
    end
  end

  // Random sink: 0..2 idle cycles after a beat, 5..10 after a packet end.
  initial begin : rnd_sink
    int   stall;
    logic hs;
    logic hl;
    stall = 0;
    forever begin
      @(negedge clock);
      hs = reset & axi_tvalid & axi_tready;
      hl = axi_tlast;
      @(posedge clock);
      #1;
      if (hs) stall = hl ? int'($urandom_range(10, 5)) : int'($urandom_range(2, 0));
      if (stall > 0) begin
        rnd_ready = 1'b0;
        stall--;
      end else begin
        rnd_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : main
    vec_t         vt[5];
    logic [W-1:0] wq[$];
    logic [BW-1:0] d;
    beat_t        held;
    int           rx0;
    int           n;
    int           p0;

    vt[0] = '{8,  64'h1,   1, 8};
    vt[1] = '{3,  64'hA,   1, 3};
    vt[2] = '{20, 64'h100, 3, 4};
    vt[3] = '{1,  64'h55,  1, 1};
    vt[4] = '{16, 64'h200, 2, 8};

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", beat_t'(in_ready), beat_t'(0));
    chk("rst_tvalid", beat_t'(axi_tvalid), beat_t'(0));
    chk("rst_pkt_count", beat_t'(pkt_count), beat_t'(0));
    chk("rst_beat_count", beat_t'(beat_count), beat_t'(0));
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", beat_t'(in_ready), beat_t'(1));
    chk("post_rst_tvalid", beat_t'(axi_tvalid), beat_t'(0));

    // Table-driven packets with an always-ready sink.
    for (int v = 0; v < 5; v++) begin
      wq.delete();
      rx0 = rx_beats;
      for (int i = 0; i < vt[v].nwords; i++) wq.push_back(vt[v].base + W'(i));
      add_expected(wq, 1'b1);
      for (int i = 0; i < vt[v].nwords; i++) begin
        if (i == vt[v].nwords - 1 && vt[v].nwords <= WORDS)
          chk("pre_last_tvalid", beat_t'(axi_tvalid), beat_t'(0));
        send_word(wq[i], i == vt[v].nwords - 1);
      end
      chk("last_tvalid", beat_t'(axi_tvalid), beat_t'(1));
      chk("last_tlast", beat_t'(axi_tlast), beat_t'(1));
      chk("last_beat", {axi_tlast, axi_tdata}, exp_q[$]);
      d = axi_tdata;
      chk("tail_word", beat_t'(d[(vt[v].tail-1)*W +: W]), beat_t'(wq[vt[v].nwords-1]));
      if (vt[v].tail < WORDS) chk("tail_pad", beat_t'(d[vt[v].tail*W +: W]), beat_t'(0));
      wait_drain("vec_drain");
      chk("vec_n_beats", beat_t'(rx_beats - rx0), beat_t'(vt[v].exp_beats));
      chk("vec_pkt_count", beat_t'(pkt_count), beat_t'(m_pkts));
      chk("vec_beat_count", beat_t'(beat_count), beat_t'(m_beats));
    end

    // Stalled sink fills the FIFO, then drains in order.
    man_ready = 1'b0;
    wq.delete();
    for (int i = 0; i < 40; i++) wq.push_back({$urandom(), $urandom()});
    add_expected(wq, 1'b0);
    for (int i = 0; i < 32; i++) send_word(wq[i], 1'b0);
    chk("full_in_ready", beat_t'(in_ready), beat_t'(0));
    chk("full_tvalid", beat_t'(axi_tvalid), beat_t'(1));
    held = {axi_tlast, axi_tdata};
    chk("stall_head", held, exp_q[0]);
    repeat (3) @(posedge clock);
    #1;
    chk("stall_hold", {axi_tlast, axi_tdata}, held);
    chk("stall_in_ready", beat_t'(in_ready), beat_t'(0));
    man_ready = 1'b1;
    @(negedge clock);
    chk("pop_cycle_in_ready", beat_t'(in_ready), beat_t'(0));
    @(posedge clock);
    #1;
    chk("after_pop_in_ready", beat_t'(in_ready), beat_t'(1));
    for (int i = 32; i < 40; i++) send_word(wq[i], 1'b0);
    wait_drain("stall_drain");
    chk("stall_beat_count", beat_t'(beat_count), beat_t'(m_beats));
    chk("stall_pkt_count", beat_t'(pkt_count), beat_t'(m_pkts));

    // Random packet lengths against a random sink.
    p0 = int'(pkt_count);
    rand_mode = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      wq.delete();
      n = int'($urandom_range(20, 1));
      for (int i = 0; i < n; i++) wq.push_back({$urandom(), $urandom()});
      send_packet(wq);
    end
    wait_drain("rand_drain");
    rand_mode = 1'b0;
    chk("rand_pkts", beat_t'(int'(pkt_count) - p0), beat_t'(1000));
    chk("rand_beat_count", beat_t'(beat_count), beat_t'(m_beats));

    // Reset in the middle of a packet with two beats queued.
    man_ready = 1'b0;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back({$urandom(), $urandom()});
    add_expected(wq, 1'b0);
    for (int i = 0; i < 16; i++) send_word(wq[i], 1'b0);
    for (int i = 0; i < 5; i++) send_word({$urandom(), $urandom()}, 1'b0);
    chk("pre_rst_tvalid", beat_t'(axi_tvalid), beat_t'(1));
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_tvalid", beat_t'(axi_tvalid), beat_t'(0));
    chk("mid_rst_in_ready", beat_t'(in_ready), beat_t'(0));
    chk("mid_rst_pkt_count", beat_t'(pkt_count), beat_t'(0));
    chk("mid_rst_beat_count", beat_t'(beat_count), beat_t'(0));
    exp_q.delete();
    m_beats = 0;
    m_pkts  = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    man_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("rel_rst_tvalid", beat_t'(axi_tvalid), beat_t'(0));
    wq.delete();
    wq.push_back(64'hDEAD_BEEF_0123_4567);
    send_packet(wq);
    chk("rst_single_beat", {axi_tlast, axi_tdata},
        {1'b1, {(BW-W){1'b0}}, 64'hDEAD_BEEF_0123_4567});
    wait_drain("rst_drain");
    chk("rst_pkt_one", beat_t'(pkt_count), beat_t'(1));
    chk("rst_beat_one", beat_t'(beat_count), beat_t'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
